iter_scheduler: RTL and testbench
=================================

# iter_scheduler

Iteration scheduler for the min-sum decoder. It sits between the load/offload front end and the layer datapath. Once a codeword's LLRs are loaded, it runs N_ITER passes, each a variable-node layer pass followed by a check-node layer pass. It can stop early when the syndrome is satisfied. It then starts the output layer and reports completion, error or abort to the front end.

## Interface
- N_ITER, 5: maximum decoding iterations (≥1)
- ITER_W, 3: width of iteration counters; must hold N_ITER
- TIMEOUT, 255: watchdog limit in cycles per layer pass (≥2)
- WD_W, 8: watchdog counter width; must hold TIMEOUT

- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request: LLRs loaded, begin decoding
- abort  in  1  cancel the current decode
- early_stop_en  in  1  early-termination enable, sampled when start is accepted
- vn_start  out  1  one-cycle pulse: begin variable-node pass
- vn_done  in  1  variable-node pass complete
- cn_start  out  1  one-cycle pulse: begin check-node pass
- cn_done  in  1  check-node pass complete
- syndrome_ok  in  1  all parity checks satisfied; qualified by cn_done
- out_start  out  1  one-cycle pulse: begin output layer
- out_done  in  1  output layer complete
- iter_idx  out  ITER_W  current iteration, 0-based
- first_iter  out  1  high while iter_idx==0: layers use channel LLRs only
- iters_used  out  ITER_W  iterations executed in the last completed decode
- busy  out  1  low only in IDLE
- done  out  1  one-cycle completion pulse
- err  out  1  sticky watchdog error

## Operation
- States: IDLE, VN_RUN, CN_RUN, OUT_RUN, DONE, ERROR.
- IDLE → VN_RUN when start=1 and abort=0. On this transition:
  - iter_idx←0
  - err←0
  - early_stop_en is latched
- Start pulses are registered. Each is asserted only in the first cycle of its RUN state.
- In every RUN state, the matching done input is ignored in the start-pulse cycle and accepted from the next cycle onward.
- VN_RUN, vn_done → CN_RUN.
- CN_RUN, cn_done, then one of:
  - latched early_stop_en and syndrome_ok → OUT_RUN.
  - else iter_idx==N_ITER-1 → OUT_RUN.
  - else iter_idx←iter_idx+1 → VN_RUN.
- Whenever CN_RUN exits to OUT_RUN, iters_used←iter_idx+1.
- OUT_RUN, out_done → DONE.
- DONE: done=1 for exactly one cycle, then → IDLE.
- Watchdog:
  - Cleared on entry to each RUN state; increments every RUN cycle.
  - Reaching TIMEOUT before the done input arrives → ERROR.
- ERROR: err←1, then → IDLE next cycle. No done pulse. err holds until the next accepted start or reset.
- abort=1 in any non-IDLE state:
  - → IDLE next cycle.
  - No further start pulses and no done pulse.
  - iter_idx←0; iters_used unchanged.
- Priority: abort > watchdog expiry > done input.
- start while busy=1 is ignored. This includes start in the DONE cycle.
- Stray done inputs outside their RUN state are ignored.
- iter_idx never exceeds N_ITER-1; there is no wrap.

## Timing
- Reset values: state IDLE; every output 0 (vn_start, cn_start, out_start, done, err, busy, iter_idx, iters_used); first_iter=1.
- start accepted at cycle T: busy=1 and vn_start=1 at T+1.
- Each layer pass takes at least 2 cycles (start cycle + done cycle). The next state is entered the cycle after done.
- With every unit answering in 1 cycle, the done pulse is at T+4·k+3, where k = iterations executed. For k=5: T+23.
- Watchdog expiry: ERROR at the cycle after TIMEOUT RUN cycles; err=1 one cycle later.
- Reset asserted mid-operation: all outputs drop to reset values immediately (asynchronous); no pulses while rst=0.

## Structure
- Shared header, alongside the codebase's common constants:
  - state encodings (3 bits)
  - ITER_W and WD_W derivation
  - active-low reset value macro
- Sub-module layer_watchdog, instantiated once:
  - inputs clr, en
  - output expired at count==TIMEOUT
  - parameters TIMEOUT, WD_W
- Remaining logic is one FSM with registered outputs.

## Test plan
- N_ITER=5, early stop off, units answer after 1 cycle → vn_start/cn_start each pulse 5 times; iter_idx steps 0..4; done at T+23; iters_used=5; err=0.
- Early stop on, syndrome_ok=1 with cn_done in iteration 2 → out_start after the 3rd cn_done; iters_used=3; no 4th vn_start.
- vn_done withheld → ERROR after 255 VN_RUN cycles; err=1; no done; next start clears err and decoding completes normally.
- abort in CN_RUN of iteration 1 → IDLE next cycle; busy=0; no out_start or done; iters_used keeps its previous value.
- start pulsed during VN_RUN and during the DONE cycle, plus stray cn_done in VN_RUN → all ignored; iteration counts unchanged.
- rst asserted during OUT_RUN → all outputs 0 and first_iter=1 at once; after release, the FSM is in IDLE and a new start decodes normally.

Source files
------------

// File: rtl/iter_scheduler_pkg.sv
// Shared constants for the iteration scheduler: FSM state encodings,
// counter width derivation and the reset level.
package iter_scheduler_pkg;

    // FSM state encodings (3-bit, kept as plain constants for legacy users)
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_VN_RUN  = 3'd1;
    localparam logic [2:0] ST_CN_RUN  = 3'd2;
    localparam logic [2:0] ST_OUT_RUN = 3'd3;
    localparam logic [2:0] ST_DONE    = 3'd4;
    localparam logic [2:0] ST_ERROR   = 3'd5;

    // Level of rst that holds the block in reset
    localparam logic RST_ACTIVE = 1'b0;

    // Bits needed to hold values 0..max_val
    function automatic int width_for(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/iter_scheduler_if.sv
// Handshake bundle between the scheduler, the front end and the layer datapath.
// master = front end / datapath side, slave = scheduler.
interface iter_scheduler_if #(
    parameter int ITER_W = 3
);
    logic              start;
    logic              abort;
    logic              early_stop_en;
    logic              vn_start;
    logic              vn_done;
    logic              cn_start;
    logic              cn_done;
    logic              syndrome_ok;
    logic              out_start;
    logic              out_done;
    logic [ITER_W-1:0] iter_idx;
    logic              first_iter;
    logic [ITER_W-1:0] iters_used;
    logic              busy;
    logic              done;
    logic              err;

    modport master (
        output start, abort, early_stop_en, vn_done, cn_done, syndrome_ok, out_done,
        input  vn_start, cn_start, out_start, iter_idx, first_iter, iters_used,
               busy, done, err
    );

    modport slave (
        input  start, abort, early_stop_en, vn_done, cn_done, syndrome_ok, out_done,
        output vn_start, cn_start, out_start, iter_idx, first_iter, iters_used,
               busy, done, err
    );

endinterface

// File: rtl/iter_scheduler_watchdog.sv
// Per-layer-pass watchdog. Counts cycles spent in a RUN state; clr restarts
// the count on entry to each RUN state.
module layer_watchdog
    import iter_scheduler_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int WD_W    = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    logic [WD_W-1:0] cnt;
    logic [WD_W:0]   cnt_inc;

    // cnt holds the RUN cycles already completed, so cnt_inc is the running
    // total including the current cycle; expiry fires in the TIMEOUT-th cycle.
    assign cnt_inc = {1'b0, cnt} + (WD_W+1)'(1);
    assign expired = en && (cnt_inc == (WD_W+1)'(TIMEOUT));

    // Cycle counter, restarted on RUN entry and frozen once expired
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ACTIVE)    cnt <= '0;
        else if (clr)             cnt <= '0;
        else if (en && !expired)  cnt <= cnt_inc[WD_W-1:0];
    end

endmodule

// File: rtl/iter_scheduler.sv
// Iteration scheduler for the min-sum decoder: sequences VN/CN layer passes
// for up to N_ITER iterations, optionally stops early on a clean syndrome,
// then runs the output layer and reports done / err to the front end.
module iter_scheduler
    import iter_scheduler_pkg::*;
#(
    parameter int N_ITER  = 5,
    parameter int ITER_W  = width_for(N_ITER),
    parameter int TIMEOUT = 255,
    parameter int WD_W    = width_for(TIMEOUT)
) (
    input logic        clk,
    input logic        rst,
    iter_scheduler_if.slave bus
);

    logic [2:0]        state, nxt;
    logic [ITER_W-1:0] iter_q, iter_nxt, used_q;
    logic              es_q;
    logic              vn_start_q, cn_start_q, out_start_q;
    logic              done_q, busy_q, err_q, first_q;
    logic              in_run, nxt_run;
    logic              wd_clr, wd_exp;
    logic              last_iter, stop_early;

    assign in_run  = (state == ST_VN_RUN) || (state == ST_CN_RUN) || (state == ST_OUT_RUN);
    assign nxt_run = (nxt == ST_VN_RUN) || (nxt == ST_CN_RUN) || (nxt == ST_OUT_RUN);
    // Every RUN entry is a state change (VN->CN, CN->VN, ...), so restart on change
    assign wd_clr  = nxt_run && (nxt != state);

    assign last_iter  = (iter_q == ITER_W'(N_ITER - 1));
    assign stop_early = es_q && bus.syndrome_ok;

    layer_watchdog #(
        .TIMEOUT (TIMEOUT),
        .WD_W    (WD_W)
    ) u_wd (
        .clk     (clk),
        .rst     (rst),
        .clr     (wd_clr),
        .en      (in_run),
        .expired (wd_exp)
    );

    // Next state: abort beats watchdog expiry, which beats the done input.
    // Done inputs are not accepted in the start-pulse cycle of their state.
    always_comb begin
        nxt = state;
        case (state)
            ST_IDLE:    if (bus.start && !bus.abort) nxt = ST_VN_RUN;
            ST_VN_RUN:  if (wd_exp)                           nxt = ST_ERROR;
                        else if (bus.vn_done && !vn_start_q)  nxt = ST_CN_RUN;
            ST_CN_RUN:  if (wd_exp)                           nxt = ST_ERROR;
                        else if (bus.cn_done && !cn_start_q)
                            nxt = (stop_early || last_iter) ? ST_OUT_RUN : ST_VN_RUN;
            ST_OUT_RUN: if (wd_exp)                           nxt = ST_ERROR;
                        else if (bus.out_done && !out_start_q) nxt = ST_DONE;
            ST_DONE,
            ST_ERROR:   nxt = ST_IDLE;
            default:    nxt = ST_IDLE;
        endcase
        if (bus.abort && (state != ST_IDLE)) nxt = ST_IDLE;
    end

    // Next iteration index: zeroed on accepted start and on abort, stepped on CN->VN
    always_comb begin
        iter_nxt = iter_q;
        if ((state == ST_IDLE) && (nxt == ST_VN_RUN))
            iter_nxt = '0;
        else if (bus.abort && (state != ST_IDLE))
            iter_nxt = '0;
        else if ((state == ST_CN_RUN) && (nxt == ST_VN_RUN))
            iter_nxt = iter_q + ITER_W'(1);
    end

    // State and registered outputs; start pulses mark the first cycle of a RUN state
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ACTIVE) begin
            state       <= ST_IDLE;
            iter_q      <= '0;
            used_q      <= '0;
            es_q        <= 1'b0;
            vn_start_q  <= 1'b0;
            cn_start_q  <= 1'b0;
            out_start_q <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
            first_q     <= 1'b1;
        end else begin
            state       <= nxt;
            iter_q      <= iter_nxt;
            first_q     <= (iter_nxt == '0);
            vn_start_q  <= (nxt == ST_VN_RUN)  && (state != ST_VN_RUN);
            cn_start_q  <= (nxt == ST_CN_RUN)  && (state != ST_CN_RUN);
            out_start_q <= (nxt == ST_OUT_RUN) && (state != ST_OUT_RUN);
            done_q      <= (nxt == ST_DONE);
            busy_q      <= (nxt != ST_IDLE);
            if ((state == ST_IDLE) && (nxt == ST_VN_RUN)) begin
                err_q <= 1'b0;
                es_q  <= bus.early_stop_en;
            end else if (state == ST_ERROR) begin
                err_q <= 1'b1;
            end
            if ((state == ST_CN_RUN) && (nxt == ST_OUT_RUN))
                used_q <= iter_q + ITER_W'(1);
        end
    end

    assign bus.vn_start   = vn_start_q;
    assign bus.cn_start   = cn_start_q;
    assign bus.out_start  = out_start_q;
    assign bus.done       = done_q;
    assign bus.busy       = busy_q;
    assign bus.err        = err_q;
    assign bus.iter_idx   = iter_q;
    assign bus.first_iter = first_q;
    assign bus.iters_used = used_q;

endmodule

// File: tb/tb_iter_scheduler.sv
// Self-checking bench for iter_scheduler. Layer units are emulated with
// randomized answer latencies; expectations come from a pass-level model.
module tb_iter_scheduler;

    localparam int N_ITER  = 5;
    localparam int ITER_W  = 3;
    localparam int TIMEOUT = 255;
    localparam int WD_W    = 8;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_bad = 0;

    iter_scheduler_if #(.ITER_W(ITER_W)) bus();

    iter_scheduler #(
        .N_ITER(N_ITER), .ITER_W(ITER_W), .TIMEOUT(TIMEOUT), .WD_W(WD_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Unit behaviour for the next decode
    int lv[N_ITER];
    int lc[N_ITER];
    int lo;
    bit syn[N_ITER];

    // Observations of the last decode (offsets relative to the start cycle)
    int o_vn, o_cn, o_out, o_done_at, o_err_c1;
    int o_busy_after, o_done_after, o_vn_after, o_used;
    int o_idx[16];
    int o_first[16];
    int prev_used;

    // Iterations a decode runs: first iteration whose CN pass reports a clean
    // syndrome when early stop is on, otherwise the full budget.
    function automatic int model_iters(input bit es);
        for (int i = 0; i < N_ITER; i++) if (es && syn[i]) return i + 1;
        return N_ITER;
    endfunction

    // A pass answered L cycles after its start pulse occupies L+1 cycles; the
    // first pass starts one cycle after start and DONE follows the output pass.
    function automatic int model_done_at(input int k);
        int t = 1;
        for (int i = 0; i < k; i++) t += (lv[i] + 1) + (lc[i] + 1);
        return t + lo + 1;
    endfunction

    task automatic set_lat(input bit rnd);
        for (int i = 0; i < N_ITER; i++) begin
            lv[i]  = rnd ? int'($urandom_range(1, 6)) : 1;
            lc[i]  = rnd ? int'($urandom_range(1, 6)) : 1;
            syn[i] = rnd ? ($urandom_range(0, 3) == 0) : 1'b0;
        end
        lo = rnd ? int'($urandom_range(1, 6)) : 1;
    endtask

    task automatic idle_inputs();
        bus.start = 0; bus.abort = 0; bus.early_stop_en = 0; bus.vn_done = 0;
        bus.cn_done = 0; bus.syndrome_ok = 0; bus.out_done = 0;
    endtask

    // Runs one decode, acting as the layer units; stray=1 also injects a start
    // in VN_RUN and in the DONE cycle plus a cn_done in VN_RUN.
    task automatic drive_decode(input bit es, input bit stray);
        int vt, ct, ot, cur_cn;
        vt = -1; ct = -1; ot = -1; cur_cn = 0;
        o_vn = 0; o_cn = 0; o_out = 0; o_done_at = -1; o_err_c1 = -1;
        @(negedge clk);
        bus.start = 1; bus.early_stop_en = es;
        for (int c = 1; c <= 600 && o_done_at < 0; c++) begin
            @(negedge clk);
            bus.start = 0; bus.early_stop_en = 1'($urandom);
            bus.vn_done = 0; bus.cn_done = 0; bus.out_done = 0;
            bus.syndrome_ok = 1'($urandom);
            if (c == 1) o_err_c1 = int'(bus.err);
            if (bus.vn_start) begin
                if (o_vn < 16) begin
                    o_idx[o_vn] = int'(bus.iter_idx);
                    o_first[o_vn] = int'(bus.first_iter);
                end
                vt = c + lv[o_vn % N_ITER];
                o_vn++;
            end
            if (bus.cn_start) begin cur_cn = o_cn % N_ITER; ct = c + lc[cur_cn]; o_cn++; end
            if (bus.out_start) begin ot = c + lo; o_out++; end
            if (bus.done) o_done_at = c;
            if (c == vt) bus.vn_done = 1;
            if (c == ct) begin bus.cn_done = 1; bus.syndrome_ok = syn[cur_cn]; end
            if (c == ot) bus.out_done = 1;
            if (stray && (c == 1 || bus.done)) bus.start = 1;
            if (stray && c == 1) bus.cn_done = 1;
        end
        @(negedge clk);
        o_busy_after = int'(bus.busy); o_done_after = int'(bus.done);
        o_vn_after = int'(bus.vn_start); o_used = int'(bus.iters_used);
        idle_inputs();
    endtask

    task automatic test_reset();
        logic [11:0] got;
        #12;
        got = {bus.vn_start, bus.cn_start, bus.out_start, bus.done, bus.err, bus.busy,
               bus.iter_idx, bus.iters_used};
        n_cmp++; if (got !== 12'h000) begin n_bad++; $display("FAIL reset_outputs: got %h want 000", got); end
        n_cmp++; if (bus.first_iter !== 1'b1) begin n_bad++; $display("FAIL reset_first_iter: got %b want 1", bus.first_iter); end
        @(negedge clk); rst = 1;
    endtask

    task automatic test_full();
        int k;
        set_lat(0);
        k = model_iters(0);
        drive_decode(0, 0);
        n_cmp++; if (o_vn !== k) begin n_bad++; $display("FAIL full_vn_pulses: got %0d want %0d", o_vn, k); end
        n_cmp++; if (o_cn !== k) begin n_bad++; $display("FAIL full_cn_pulses: got %0d want %0d", o_cn, k); end
        n_cmp++; if (o_out !== 1) begin n_bad++; $display("FAIL full_out_pulses: got %0d want 1", o_out); end
        n_cmp++; if (o_done_at !== model_done_at(k)) begin n_bad++; $display("FAIL full_done_time: got %0d want %0d", o_done_at, model_done_at(k)); end
        n_cmp++; if (o_used !== k) begin n_bad++; $display("FAIL full_iters_used: got %0d want %0d", o_used, k); end
        n_cmp++; if (o_err_c1 !== 0 || bus.err !== 1'b0) begin n_bad++; $display("FAIL full_err: got %0d/%b want 0", o_err_c1, bus.err); end
        n_cmp++; if (o_done_after !== 0 || o_busy_after !== 0) begin n_bad++; $display("FAIL full_done_one_cycle: got done=%0d busy=%0d want 0/0", o_done_after, o_busy_after); end
        for (int i = 0; i < k && i < 16; i++) begin
            n_cmp++; if (o_idx[i] !== i) begin n_bad++; $display("FAIL full_iter_idx[%0d]: got %0d want %0d", i, o_idx[i], i); end
            n_cmp++; if (o_first[i] !== int'(i == 0)) begin n_bad++; $display("FAIL full_first_iter[%0d]: got %0d want %0d", i, o_first[i], int'(i == 0)); end
        end
        prev_used = k;
    endtask

    task automatic test_early_stop();
        int k;
        set_lat(0);
        syn[2] = 1'b1;
        k = model_iters(1);
        drive_decode(1, 0);
        n_cmp++; if (o_vn !== k) begin n_bad++; $display("FAIL early_vn_pulses: got %0d want %0d", o_vn, k); end
        n_cmp++; if (o_cn !== k) begin n_bad++; $display("FAIL early_cn_pulses: got %0d want %0d", o_cn, k); end
        n_cmp++; if (o_done_at !== model_done_at(k)) begin n_bad++; $display("FAIL early_done_time: got %0d want %0d", o_done_at, model_done_at(k)); end
        n_cmp++; if (o_used !== k) begin n_bad++; $display("FAIL early_iters_used: got %0d want %0d", o_used, k); end
        prev_used = k;
    endtask

    task automatic test_abort();
        int vt, ct, cn_seen, abort_c, n_after;
        vt = -1; ct = -1; cn_seen = 0; abort_c = -1; n_after = 0;
        @(negedge clk);
        bus.start = 1; bus.early_stop_en = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            bus.start = 0; bus.abort = 0; bus.vn_done = 0; bus.cn_done = 0;
            if (abort_c > 0 && c == abort_c + 1) begin
                n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL abort_busy: got %b want 0", bus.busy); end
                n_cmp++; if (int'(bus.iter_idx) !== 0 || bus.first_iter !== 1'b1) begin n_bad++; $display("FAIL abort_iter_idx: got %0d/%b want 0/1", bus.iter_idx, bus.first_iter); end
                n_cmp++; if (int'(bus.iters_used) !== prev_used) begin n_bad++; $display("FAIL abort_iters_used: got %0d want %0d", bus.iters_used, prev_used); end
            end
            if (abort_c > 0 && c > abort_c)
                n_after += int'(bus.vn_start) + int'(bus.cn_start) + int'(bus.out_start) + int'(bus.done);
            if (bus.vn_start) vt = c + 1;
            if (bus.cn_start) begin
                if (cn_seen == 1) begin bus.abort = 1; abort_c = c; end
                ct = c + 1;
                cn_seen++;
            end
            if (c == vt) bus.vn_done = 1;
            if (c == ct) bus.cn_done = 1;
        end
        idle_inputs();
        n_cmp++; if (abort_c < 0) begin n_bad++; $display("FAIL abort_reached: got none want cn_start of iteration 1"); end
        n_cmp++; if (n_after !== 0) begin n_bad++; $display("FAIL abort_no_pulses: got %0d pulses want 0", n_after); end
    endtask

    task automatic test_watchdog();
        int err_at, busy_err, n_done;
        err_at = -1; busy_err = -1; n_done = 0;
        @(negedge clk);
        bus.start = 1; bus.early_stop_en = 0;
        for (int c = 1; c <= TIMEOUT + 6; c++) begin
            @(negedge clk);
            bus.start = 0;
            if (bus.err && err_at < 0) err_at = c;
            if (c == TIMEOUT + 1) busy_err = int'(bus.busy);
            if (bus.done) n_done++;
        end
        n_cmp++; if (err_at !== TIMEOUT + 2) begin n_bad++; $display("FAIL wd_err_time: got %0d want %0d", err_at, TIMEOUT + 2); end
        n_cmp++; if (busy_err !== 1) begin n_bad++; $display("FAIL wd_busy_in_error: got %0d want 1", busy_err); end
        n_cmp++; if (n_done !== 0) begin n_bad++; $display("FAIL wd_no_done: got %0d want 0", n_done); end
        n_cmp++; if (bus.err !== 1'b1 || bus.busy !== 1'b0) begin n_bad++; $display("FAIL wd_sticky: got err=%b busy=%b want 1/0", bus.err, bus.busy); end
        n_cmp++; if (int'(bus.iters_used) !== prev_used) begin n_bad++; $display("FAIL wd_iters_used: got %0d want %0d", bus.iters_used, prev_used); end
        set_lat(0);
        drive_decode(0, 0);
        n_cmp++; if (o_err_c1 !== 0) begin n_bad++; $display("FAIL wd_err_cleared: got %0d want 0", o_err_c1); end
        n_cmp++; if (o_done_at !== model_done_at(N_ITER)) begin n_bad++; $display("FAIL wd_recover_done: got %0d want %0d", o_done_at, model_done_at(N_ITER)); end
        n_cmp++; if (o_used !== N_ITER) begin n_bad++; $display("FAIL wd_recover_used: got %0d want %0d", o_used, N_ITER); end
        prev_used = N_ITER;
    endtask

    task automatic test_ignored();
        int k;
        set_lat(0);
        k = model_iters(0);
        drive_decode(0, 1);
        n_cmp++; if (o_vn !== k || o_cn !== k) begin n_bad++; $display("FAIL ign_pulses: got vn=%0d cn=%0d want %0d", o_vn, o_cn, k); end
        n_cmp++; if (o_done_at !== model_done_at(k)) begin n_bad++; $display("FAIL ign_done_time: got %0d want %0d", o_done_at, model_done_at(k)); end
        n_cmp++; if (o_used !== k) begin n_bad++; $display("FAIL ign_iters_used: got %0d want %0d", o_used, k); end
        n_cmp++; if (o_busy_after !== 0 || o_vn_after !== 0) begin n_bad++; $display("FAIL ign_start_in_done: got busy=%0d vn_start=%0d want 0/0", o_busy_after, o_vn_after); end
        prev_used = k;
    endtask

    task automatic test_random();
        int k;
        bit es;
        for (int r = 0; r < 8; r++) begin
            set_lat(1);
            es = 1'($urandom);
            k = model_iters(es);
            drive_decode(es, 0);
            n_cmp++; if (o_vn !== k || o_cn !== k) begin n_bad++; $display("FAIL rnd%0d_pulses: got vn=%0d cn=%0d want %0d", r, o_vn, o_cn, k); end
            n_cmp++; if (o_done_at !== model_done_at(k)) begin n_bad++; $display("FAIL rnd%0d_done_time: got %0d want %0d", r, o_done_at, model_done_at(k)); end
            n_cmp++; if (o_used !== k) begin n_bad++; $display("FAIL rnd%0d_iters_used: got %0d want %0d", r, o_used, k); end
            for (int i = 0; i < k && i < 16; i++) begin
                n_cmp++; if (o_idx[i] !== i) begin n_bad++; $display("FAIL rnd%0d_iter_idx[%0d]: got %0d want %0d", r, i, o_idx[i], i); end
            end
            prev_used = k;
        end
    endtask

    task automatic test_rst_mid();
        int vt, ct;
        bit seen;
        logic [11:0] got;
        logic [4:0]  pulses;
        vt = -1; ct = -1; seen = 0; pulses = '0;
        set_lat(0);
        @(negedge clk);
        bus.start = 1;
        for (int c = 1; c <= 60 && !seen; c++) begin
            @(negedge clk);
            bus.start = 0; bus.vn_done = 0; bus.cn_done = 0;
            if (bus.vn_start) vt = c + 1;
            if (bus.cn_start) ct = c + 1;
            if (c == vt) bus.vn_done = 1;
            if (c == ct) bus.cn_done = 1;
            if (bus.out_start) seen = 1;
        end
        idle_inputs();
        n_cmp++; if (seen !== 1'b1) begin n_bad++; $display("FAIL rst_reach_out: got %b want 1", seen); end
        #2 rst = 0;
        #1;
        got = {bus.vn_start, bus.cn_start, bus.out_start, bus.done, bus.err, bus.busy,
               bus.iter_idx, bus.iters_used};
        n_cmp++; if (got !== 12'h000) begin n_bad++; $display("FAIL rst_async_outputs: got %h want 000", got); end
        n_cmp++; if (bus.first_iter !== 1'b1) begin n_bad++; $display("FAIL rst_async_first_iter: got %b want 1", bus.first_iter); end
        repeat (3) begin
            @(negedge clk);
            pulses |= {bus.vn_start, bus.cn_start, bus.out_start, bus.done, bus.busy};
        end
        n_cmp++; if (pulses !== 5'b0) begin n_bad++; $display("FAIL rst_held_quiet: got %b want 00000", pulses); end
        rst = 1;
        drive_decode(0, 0);
        n_cmp++; if (o_done_at !== model_done_at(N_ITER)) begin n_bad++; $display("FAIL rst_recover_done: got %0d want %0d", o_done_at, model_done_at(N_ITER)); end
        n_cmp++; if (o_used !== N_ITER) begin n_bad++; $display("FAIL rst_recover_used: got %0d want %0d", o_used, N_ITER); end
    endtask

    initial begin
        rst = 0;
        prev_used = 0;
        idle_inputs();
        test_reset();
        test_full();
        test_early_stop();
        test_abort();
        test_watchdog();
        test_ignored();
        test_random();
        test_rst_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
